// File: rtl/trap_sequencer.sv
// Trap sequencer for the multicycle rv32ima core. It arbitrates exceptions, interrupts,
// MRET and WFI, and strobes the CSR exception handler with a registered cause/pc/badaddr.
module trap_sequencer #(
    parameter int unsigned WFI_TIMEOUT = 0,
    parameter logic [31:0] IRQ_MASK    = 32'h0000_0888
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_boundary,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        mret_valid,
    input  logic        wfi_valid,
    input  logic [31:0] cur_pc,
    input  logic [31:0] mstatus,
    input  logic [31:0] mie,
    input  logic [31:0] mip,
    input  logic [1:0]  privilege_mode,
    output logic        exception_event,
    output logic        mret,
    output logic        wfi_event,
    output logic [31:0] cause,
    output logic [31:0] pc,
    output logic [31:0] badaddr,
    output logic        trap_busy,
    output logic        trap_done,
    output logic        wfi_wake,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_REDIRECT = 2'd2,
        S_WFI_WAIT = 2'd3
    } state_t;

    localparam bit          L_TIMEOUT_EN   = (WFI_TIMEOUT != 0);
    localparam logic [31:0] L_TIMEOUT_LAST = (WFI_TIMEOUT == 0) ? 32'd0 : 32'(WFI_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_exception_event;
    logic        r_mret;
    logic        r_wfi_event;
    logic        r_trap_busy;
    logic        r_trap_done;
    logic        r_wfi_wake;
    logic [31:0] r_cause;
    logic [31:0] r_pc;
    logic [31:0] r_badaddr;
    logic [31:0] r_wait_cnt;

    logic [31:0] w_pend;
    logic        w_global_ie;
    logic        w_irq_take;
    logic [4:0]  w_irq_code;
    logic        w_timeout;
    logic        w_wake;
    logic        w_next_exc_event;
    logic        w_next_mret;
    logic        w_next_wfi_wake;
    logic        w_cap_exc;
    logic        w_cap_irq;
    logic        w_unused;

    // Fixed priority MEI > MSI > MTI; any other unmasked bit falls back to its lowest index.
    function automatic logic [4:0] irq_code(input logic [31:0] p);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (p[i]) c = 5'(i);
        end
        if (p[7])  c = 5'd7;
        if (p[3])  c = 5'd3;
        if (p[11]) c = 5'd11;
        return c;
    endfunction

    assign w_pend      = mip & mie & IRQ_MASK;
    assign w_global_ie = mstatus[3] | (privilege_mode != 2'b11);
    assign w_irq_take  = instr_boundary & (w_pend != 32'd0) & w_global_ie;
    assign w_irq_code  = irq_code(w_pend);
    assign w_timeout   = L_TIMEOUT_EN && (r_wait_cnt == L_TIMEOUT_LAST);
    assign w_wake      = (w_pend != 32'd0) | w_timeout;
    assign w_unused    = ^{mstatus[31:4], mstatus[2:0]};

    // Requests are level inputs sampled only in IDLE; trap_busy high means no request is accepted.
    always_comb begin
        w_next_state     = r_state;
        w_next_exc_event = 1'b0;
        w_next_mret      = 1'b0;
        w_next_wfi_wake  = 1'b0;
        w_cap_exc        = 1'b0;
        w_cap_irq        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (exc_valid) begin
                    w_next_state     = S_ISSUE;
                    w_next_exc_event = 1'b1;
                    w_cap_exc        = 1'b1;
                end else if (mret_valid) begin
                    w_next_state = S_ISSUE;
                    w_next_mret  = 1'b1;
                end else if (wfi_valid) begin
                    w_next_state = S_WFI_WAIT;
                end else if (w_irq_take) begin
                    w_next_state     = S_ISSUE;
                    w_next_exc_event = 1'b1;
                    w_cap_irq        = 1'b1;
                end
            end
            S_ISSUE:    w_next_state = S_REDIRECT;
            S_REDIRECT: w_next_state = S_IDLE;
            S_WFI_WAIT: begin
                if (w_wake) begin
                    w_next_state    = S_IDLE;
                    w_next_wfi_wake = 1'b1;
                end
            end
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_exception_event <= 1'b0;
            r_mret            <= 1'b0;
            r_wfi_event       <= 1'b0;
            r_trap_busy       <= 1'b0;
            r_trap_done       <= 1'b0;
            r_wfi_wake        <= 1'b0;
            r_cause           <= 32'd0;
            r_pc              <= 32'd0;
            r_badaddr         <= 32'd0;
            r_wait_cnt        <= 32'd0;
        end else begin
            r_state           <= w_next_state;
            r_exception_event <= w_next_exc_event;
            r_mret            <= w_next_mret;
            r_wfi_event       <= (w_next_state == S_WFI_WAIT);
            r_trap_busy       <= (w_next_state != S_IDLE);
            r_trap_done       <= (w_next_state == S_REDIRECT);
            r_wfi_wake        <= w_next_wfi_wake;
            if (w_cap_exc) begin
                r_cause   <= {28'd0, exc_cause};
                r_pc      <= exc_pc;
                r_badaddr <= (exc_tval == 32'hFFFF_FFFF) ? exc_pc : exc_tval;
            end else if (w_cap_irq) begin
                r_cause   <= {1'b1, 26'd0, w_irq_code};
                r_pc      <= cur_pc;
                r_badaddr <= 32'd0;
            end
            // Counter is zero on the first WAIT cycle and saturates rather than wrapping.
            if (r_state != S_WFI_WAIT) begin
                r_wait_cnt <= 32'd0;
            end else if (r_wait_cnt != 32'hFFFF_FFFF) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end
        end
    end

    assign exception_event = r_exception_event;
    assign mret            = r_mret;
    assign wfi_event       = r_wfi_event;
    assign cause           = r_cause;
    assign pc              = r_pc;
    assign badaddr         = r_badaddr;
    assign trap_busy       = r_trap_busy;
    assign trap_done       = r_trap_done;
    assign wfi_wake        = r_wfi_wake;
    assign o_dbg_state     = r_state;

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Sequences all control-flow traps for the multicycle rv32ima core: synchronous exceptions, machine interrupts (MEI/MSI/MTI), MRET and WFI.
- Arbitrates these requests, then drives the CSR exception handler's exception_event/mret/wfi_event strobes with registered cause/pc/badaddr.
- Handshakes with the core FSM so it stalls until exception_next_pc is valid.
- Sits between the core control FSM and the CSR exception handler.

Parameters:
WFI_TIMEOUT, 0, cycles before WFI self-wakes; 0 disables the timeout.
IRQ_MASK, 32'h0000_0888, mip/mie bits eligible as interrupts (MEIP bit 11, MTIP bit 7, MSIP bit 3).

Ports:
clk  in  1  clock
reset  in  1  reset
instr_boundary  in  1  core is between instructions; interrupts may be taken
exc_valid  in  1  synchronous exception raised by the current instruction
exc_cause  in  4  exception code (0..15)
exc_pc  in  32  pc of the faulting instruction
exc_tval  in  32  trap value; all-ones selects the pc
mret_valid  in  1  MRET executed
wfi_valid  in  1  WFI executed
cur_pc  in  32  pc of the next instruction at the boundary
mstatus  in  32  from the CSR unit
mie  in  32  from the CSR unit
mip  in  32  from the CSR unit
privilege_mode  in  2  from the CSR unit
exception_event  out  1  one-cycle strobe to the CSR unit
mret  out  1  one-cycle strobe to the CSR unit
wfi_event  out  1  high while waiting for an interrupt
cause  out  32  mcause value
pc  out  32  mepc value
badaddr  out  32  mtval value
trap_busy  out  1  core must hold its state
trap_done  out  1  one-cycle pulse; core loads exception_next_pc
wfi_wake  out  1  one-cycle pulse; core resumes at pc+4

Behaviour:
Clock and reset:
- Single clock clk. Reset is synchronous and active-high.
- Reset value of every output is 0; state goes to IDLE.
- Reset in any state aborts the operation; no strobe is emitted in the cycle after reset.

States: IDLE, ISSUE, REDIRECT, WFI_WAIT.
- trap_busy = (state != IDLE), registered.
- Requests are sampled only in IDLE; inputs in other states are ignored.

IDLE arbitration (one request per cycle), priority exc_valid > mret_valid > wfi_valid > interrupt:
- Interrupt is taken only when instr_boundary=1 and pend != 0, where pend = mip & mie & IRQ_MASK.
- Interrupts also require global enable: mstatus[3] (MIE) = 1 or privilege_mode != 2'b11.
- Interrupt priority: MEI (11) > MSI (3) > MTI (7).

Capture on the IDLE->ISSUE transition:
- Exception: cause = {28'b0, exc_cause}; pc = exc_pc; badaddr = exc_tval.
- Interrupt: cause = 32'h8000_0000 | code; pc = cur_pc; badaddr = 0.
- MRET: cause, pc and badaddr are held.

ISSUE:
- Lasts exactly 1 cycle.
- exception_event=1 (exception or interrupt) or mret=1, never both.
- Next state: REDIRECT.

REDIRECT:
- trap_done=1 for 1 cycle; the CSR unit's registered exception_next_pc/exception_select are valid this cycle.
- Next state: IDLE.

Latency:
- Request cycle N, strobe N+1, trap_done N+2.
- A new request is accepted at N+3 at the earliest.

WFI_WAIT:
- Entered from IDLE on wfi_valid; wfi_event=1 throughout.
- Wakes when (mip & mie & IRQ_MASK) != 0 regardless of mstatus.MIE.
- If WFI_TIMEOUT != 0, it also wakes when the wait counter reaches WFI_TIMEOUT-1.
- Wait counter: 32-bit, cleared on entry, saturating.
- On wake: wfi_wake=1 for 1 cycle, wfi_event=0, state goes to IDLE; no trap is taken here.
- A pending enabled interrupt is then taken via IDLE arbitration on the next instr_boundary.

Simultaneous events:
- exc_valid with a pending interrupt: the exception wins. The interrupt stays pending (level) and is taken at a later boundary.
- mret_valid with exc_valid: the exception wins and mret is never strobed.

Outputs cause, pc and badaddr hold their values until the next capture.

Test Plan:
- Illegal instruction: exc_valid=1, exc_cause=2, exc_pc=0x8000_0100, exc_tval=0x0000_0013 -> next cycle exception_event=1, cause=2, pc=0x8000_0100, badaddr=0x13; one cycle later trap_done=1, trap_busy=1 for exactly 2 cycles.
- Interrupt priority: mstatus[3]=1, mie=mip=0x888, instr_boundary=1, cur_pc=0x40 -> cause=0x8000_000B, pc=0x40, badaddr=0. Clearing mip[11] and repeating gives 0x8000_0003, then with only mip[7] gives 0x8000_0007.
- Interrupt masking:
  - mstatus[3]=0, privilege_mode=3, mip=mie=0x80 -> no strobe.
  - Same with privilege_mode=0 -> cause=0x8000_0007.
  - instr_boundary=0 -> no strobe.
- Simultaneous events:
  - exc_valid (cause 11) with pending MTI -> single exception_event with cause=11; MTI is taken at the next boundary.
  - exc_valid with mret_valid -> mret stays 0.
- WFI:
  - wfi_valid, mip=0 for 20 cycles -> wfi_event=1, no wake.
  - Set mip[7] with mie[7]=1, mstatus[3]=0 -> wfi_wake the next cycle, no exception_event.
  - WFI_TIMEOUT=8 with no interrupt -> wfi_wake 8 cycles after entry.
- Reset mid-operation: assert reset during ISSUE -> next cycle all outputs 0, state IDLE, no trap_done; a request one cycle after reset release completes normally.
